interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
Sequences the decode-stage control unit during interrupt entry and RTI return.
- Freezes fetch and drains in-flight instructions.
- Injects stack micro-ops that override the decoded op: push PC high/low and flags on entry; pop them in reverse on return.
- Redirects fetch to the interrupt vector on entry.
- Sits beside the decode control unit; decode muxes its own outputs with the micro-op when o_inject=1.

Parameters:
PC_WIDTH, 32, width of the captured resume PC.
VECTOR_ADDR, 32'h0000_0000, fetch target on interrupt entry.
DRAIN_CYCLES, 3, NOP cycles needed to retire in-flight instructions (1..7).

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_interrupt  in  1  external interrupt request; level, rising-edge sensitive.
i_rti  in  1  one-cycle pulse: decode recognised RTI.
i_stall  in  1  pipeline stall from hazard logic; sequencer holds state.
i_next_pc  in  PC_WIDTH  PC of next instruction to execute (includes taken-branch targets).
i_next_pc_valid  in  1  i_next_pc is meaningful this cycle.
o_inject  out  1  decode must use o_micro_op instead of the fetched op.
o_micro_op  out  3  injected micro-op (encoding in package).
o_freeze_fetch  out  1  hold PC and the fetch/decode register.
o_saved_pc  out  PC_WIDTH  PC to push on entry.
o_load_vector  out  1  one-cycle pulse: fetch PC <= VECTOR_ADDR.
o_resume  out  1  one-cycle pulse: return sequence done; fetch restarts from the popped PC.
o_irq_ack  out  1  one-cycle pulse when the interrupt is accepted.
o_busy  out  1  state != IDLE.

Behaviour:
Reset: state=IDLE, pending=0, drain counter=0, o_saved_pc=0. All outputs are 0 except o_micro_op=UOP_NONE.

Pending latch:
- Set on a rising edge of i_interrupt (previous-sample register).
- Cleared when entering DRAIN_I.
- Repeated edges while pending collapse into one request.

IDLE transitions:
- pending=1 -> DRAIN_I, with o_irq_ack=1 that cycle.
- else i_rti=1 -> DRAIN_R.
- If pending and i_rti occur together, the interrupt wins and the RTI is dropped; decode re-fetches it after return.

DRAIN_I / DRAIN_R:
- Outputs: o_freeze_fetch=1, o_inject=1, uop=UOP_NOP.
- Counter counts 0..DRAIN_CYCLES-1.
- In DRAIN_I, o_saved_pc <= i_next_pc in every cycle with i_next_pc_valid=1, so the last valid value (including a branch target resolved mid-drain) is the one kept.
- When the count ends: DRAIN_I -> PUSH_HI; DRAIN_R -> POP_FL.

Entry stack sequence:
- PUSH_HI -> PUSH_LO -> PUSH_FL -> VECTOR.
- Each state is one cycle with o_inject=1 and the matching uop.

VECTOR:
- o_load_vector=1, o_inject=1, uop=UOP_NOP, freeze still asserted.
- Next state IDLE; fetch resumes the following cycle.

Return stack sequence:
- POP_FL -> POP_LO -> POP_HI -> RESUME.
- RESUME: o_resume=1, uop=UOP_NOP; next state IDLE.

Stall:
- While i_stall=1, state, counter and o_saved_pc hold.
- Outputs stay at the current state's values; a micro-op is presented again until accepted.

Interrupt during a sequence:
- A new edge sets pending.
- It is serviced from IDLE after the current sequence completes; no nesting.

Latency (no stalls), counted from the i_interrupt edge cycle (T=0; IDLE samples pending at T+1):
- o_irq_ack at T+1.
- First push at T+2+DRAIN_CYCLES.
- o_load_vector at T+5+DRAIN_CYCLES.

Reset mid-sequence: returns to IDLE next edge and discards the pending request.

Decomposition:
Package irq_seq_pkg holds:
- Micro-op constants: UOP_NONE=000, UOP_NOP=001, UOP_PUSH_PC_HI=010, UOP_PUSH_PC_LO=011, UOP_PUSH_FLAGS=100, UOP_POP_FLAGS=101, UOP_POP_PC_LO=110, UOP_POP_PC_HI=111.
- State encodings.

No sub-module is needed; the rising-edge pending latch is optionally split out as irq_edge_latch.

Test Plan:
1. Reset, DRAIN_CYCLES=3, interrupt edge at T with i_next_pc=0x40 valid -> ack T+1; NOP T+2..T+4; PUSH_HI/LO/FL T+5..T+7 with o_saved_pc=0x40; o_load_vector T+8; o_busy low T+9.
2. i_rti pulse in IDLE -> 3 NOPs, then POP_FLAGS, POP_PC_LO, POP_PC_HI, then o_resume pulse; o_load_vector never asserted.
3. i_stall=1 for 2 cycles during PUSH_LO -> UOP_PUSH_PC_LO held 3 cycles; total sequence 2 cycles longer; no state skipped.
4. Branch mid-drain (i_next_pc 0x40 then 0x100 valid) -> pushed o_saved_pc=0x100.
5. Second interrupt edge during PUSH_HI, plus simultaneous interrupt+i_rti in IDLE -> second entry begins right after VECTOR→IDLE; simultaneous case takes the interrupt and drops the RTI.
6. i_reset asserted in POP_LO with pending=1 -> next cycle IDLE, all outputs at reset values, no ack afterwards.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_seq_pkg
// Description : Micro-op encodings and state encodings shared by the
//               interrupt sequencer, its interface and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_seq_pkg;

  // Micro-ops presented to decode while o_inject is high.
  localparam logic [2:0] UOP_NONE       = 3'b000;
  localparam logic [2:0] UOP_NOP        = 3'b001;
  localparam logic [2:0] UOP_PUSH_PC_HI = 3'b010;
  localparam logic [2:0] UOP_PUSH_PC_LO = 3'b011;
  localparam logic [2:0] UOP_PUSH_FLAGS = 3'b100;
  localparam logic [2:0] UOP_POP_FLAGS  = 3'b101;
  localparam logic [2:0] UOP_POP_PC_LO  = 3'b110;
  localparam logic [2:0] UOP_POP_PC_HI  = 3'b111;

  // Sequencer states: entry path DRAIN_I..VECTOR, return path DRAIN_R..RESUME.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DRAIN_I = 4'd1,
    ST_DRAIN_R = 4'd2,
    ST_PUSH_HI = 4'd3,
    ST_PUSH_LO = 4'd4,
    ST_PUSH_FL = 4'd5,
    ST_VECTOR  = 4'd6,
    ST_POP_FL  = 4'd7,
    ST_POP_LO  = 4'd8,
    ST_POP_HI  = 4'd9,
    ST_RESUME  = 4'd10
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer_if
// Description : Decode/fetch side signals of the interrupt sequencer.
//               master = pipeline side (drives requests), slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                i_interrupt;
  logic                i_rti;
  logic                i_stall;
  logic [PC_WIDTH-1:0] i_next_pc;
  logic                i_next_pc_valid;

  logic                o_inject;
  logic [2:0]          o_micro_op;
  logic                o_freeze_fetch;
  logic [PC_WIDTH-1:0] o_saved_pc;
  logic                o_load_vector;
  logic [PC_WIDTH-1:0] o_vector_addr;
  logic                o_resume;
  logic                o_irq_ack;
  logic                o_busy;

  modport master (
    output i_interrupt, i_rti, i_stall, i_next_pc, i_next_pc_valid,
    input  o_inject, o_micro_op, o_freeze_fetch, o_saved_pc, o_load_vector,
           o_vector_addr, o_resume, o_irq_ack, o_busy
  );

  modport slave (
    input  i_interrupt, i_rti, i_stall, i_next_pc, i_next_pc_valid,
    output o_inject, o_micro_op, o_freeze_fetch, o_saved_pc, o_load_vector,
           o_vector_addr, o_resume, o_irq_ack, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer
// Description : Drives decode through interrupt entry (drain, push PC hi/lo
//               and flags, vector) and RTI return (drain, pop flags/PC lo/hi,
//               resume) by injecting stack micro-ops.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer
  import irq_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = '0,
  parameter int                  DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  interrupt_sequencer_if.slave  bus
);

  // Drain counter is 3 bits wide, enough for DRAIN_CYCLES up to 7.
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] saved_pc_q, saved_pc_d;
  logic                pending_q, pending_d;
  logic                irq_prev_q;

  logic                rise_w;
  logic                enter_irq_w;
  logic                inject_w;
  logic [2:0]          uop_w;
  logic                freeze_w;
  logic                load_vector_w;
  logic                resume_w;
  logic                ack_w;

  // A request is a 0->1 transition of the interrupt level.
  assign rise_w = bus.i_interrupt & ~irq_prev_q;

  // Edges collapse into one pending request; accepting it clears it, but an
  // edge arriving in the very cycle of acceptance is kept for later service.
  assign pending_d = (pending_q & ~enter_irq_w) | rise_w;

  // State, counter, captured PC and pending request registers.
  always_ff @(posedge i_clk) begin
    // Sampled even in reset so a level held through reset is not an edge.
    irq_prev_q <= bus.i_interrupt;
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      saved_pc_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      saved_pc_q <= saved_pc_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state and micro-op selection; a stall freezes every transition
  // while the current state's outputs stay on the bus.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_pc_d    = saved_pc_q;
    enter_irq_w   = 1'b0;
    inject_w      = 1'b0;
    uop_w         = UOP_NONE;
    freeze_w      = 1'b0;
    load_vector_w = 1'b0;
    resume_w      = 1'b0;
    ack_w         = 1'b0;

    if (state_q != ST_IDLE) begin
      inject_w = 1'b1;
      freeze_w = 1'b1;
      uop_w    = UOP_NOP;
    end

    case (state_q)
      ST_IDLE: begin
        // Interrupt beats a coincident RTI; decode re-fetches the RTI later.
        if (pending_q) begin
          if (!bus.i_stall) begin
            ack_w       = 1'b1;
            enter_irq_w = 1'b1;
            state_d     = ST_DRAIN_I;
          end
        end else if (bus.i_rti && !bus.i_stall) begin
          state_d = ST_DRAIN_R;
        end
        cnt_d = 3'd0;
      end

      ST_DRAIN_I, ST_DRAIN_R: begin
        if (!bus.i_stall) begin
          // Last valid PC wins so a branch resolved mid-drain is honoured.
          if (state_q == ST_DRAIN_I && bus.i_next_pc_valid) begin
            saved_pc_d = bus.i_next_pc;
          end
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = 3'd0;
            state_d = (state_q == ST_DRAIN_I) ? ST_PUSH_HI : ST_POP_FL;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_PUSH_HI: begin
        uop_w = UOP_PUSH_PC_HI;
        if (!bus.i_stall) state_d = ST_PUSH_LO;
      end

      ST_PUSH_LO: begin
        uop_w = UOP_PUSH_PC_LO;
        if (!bus.i_stall) state_d = ST_PUSH_FL;
      end

      ST_PUSH_FL: begin
        uop_w = UOP_PUSH_FLAGS;
        if (!bus.i_stall) state_d = ST_VECTOR;
      end

      ST_VECTOR: begin
        load_vector_w = 1'b1;
        if (!bus.i_stall) state_d = ST_IDLE;
      end

      ST_POP_FL: begin
        uop_w = UOP_POP_FLAGS;
        if (!bus.i_stall) state_d = ST_POP_LO;
      end

      ST_POP_LO: begin
        uop_w = UOP_POP_PC_LO;
        if (!bus.i_stall) state_d = ST_POP_HI;
      end

      ST_POP_HI: begin
        uop_w = UOP_POP_PC_HI;
        if (!bus.i_stall) state_d = ST_RESUME;
      end

      ST_RESUME: begin
        resume_w = 1'b1;
        if (!bus.i_stall) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_inject       = inject_w;
  assign bus.o_micro_op     = uop_w;
  assign bus.o_freeze_fetch = freeze_w;
  assign bus.o_saved_pc     = saved_pc_q;
  assign bus.o_load_vector  = load_vector_w;
  assign bus.o_vector_addr  = VECTOR_ADDR;
  assign bus.o_resume       = resume_w;
  assign bus.o_irq_ack      = ack_w;
  assign bus.o_busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_sequencer
// Description : Self-checking bench for interrupt_sequencer (DRAIN_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;
  import irq_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_sequencer_if #(.PC_WIDTH(32)) bus();

  interrupt_sequencer #(
    .PC_WIDTH    (32),
    .VECTOR_ADDR (32'h0000_0000),
    .DRAIN_CYCLES(3)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Output vector: {inject, uop[2:0], freeze, load_vector, resume, ack, busy}
  localparam logic [8:0] V_IDLE = 9'b0_000_0_0_0_0_0;
  localparam logic [8:0] V_ACK  = 9'b0_000_0_0_0_1_0;
  localparam logic [8:0] V_NOP  = 9'b1_001_1_0_0_0_1;
  localparam logic [8:0] V_PHI  = 9'b1_010_1_0_0_0_1;
  localparam logic [8:0] V_PLO  = 9'b1_011_1_0_0_0_1;
  localparam logic [8:0] V_PFL  = 9'b1_100_1_0_0_0_1;
  localparam logic [8:0] V_QFL  = 9'b1_101_1_0_0_0_1;
  localparam logic [8:0] V_QLO  = 9'b1_110_1_0_0_0_1;
  localparam logic [8:0] V_QHI  = 9'b1_111_1_0_0_0_1;
  localparam logic [8:0] V_VEC  = 9'b1_001_1_1_0_0_1;
  localparam logic [8:0] V_RES  = 9'b1_001_1_0_1_0_1;

  typedef struct {
    logic [8:0]  v;
    bit          chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] obs();
    return {bus.o_inject, bus.o_micro_op, bus.o_freeze_fetch, bus.o_load_vector,
            bus.o_resume, bus.o_irq_ack, bus.o_busy};
  endfunction

  // Queue one cycle of expected outputs.
  task automatic expect_v(input logic [8:0] v, input bit c, input logic [31:0] pc);
    exp_t e;
    e.v = v; e.chk_pc = c; e.pc = pc;
    sb.push_back(e);
  endtask

  // Queue a full interrupt entry starting at the ack cycle.
  task automatic expect_entry(input logic [31:0] pc);
    expect_v(V_ACK, 0, 0);
    repeat (3) expect_v(V_NOP, 0, 0);
    expect_v(V_PHI, 1, pc);
    expect_v(V_PLO, 1, pc);
    expect_v(V_PFL, 1, pc);
    expect_v(V_VEC, 0, 0);
  endtask

  // Apply one cycle of inputs after the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic intr, input logic rti,
                       input logic stall, input logic [31:0] pc, input logic pcv);
    @(negedge clk);
    rst                 = r;
    bus.i_interrupt     = intr;
    bus.i_rti           = rti;
    bus.i_stall         = stall;
    bus.i_next_pc       = pc;
    bus.i_next_pc_valid = pcv;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.delete();
    drive(1, 0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 0);
    expect_v(V_IDLE, 1, 32'h0);
    expect_v(V_IDLE, 1, 32'h0);
    for (int k = 0; sb.size() > 0; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL reset k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL reset k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_entry();
    exp_t e;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);
    expect_entry(32'h40);
    expect_v(V_IDLE, 0, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      drive(0, k >= 1, 0, 0, 32'h40, 1);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL entry k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL entry k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_rti();
    exp_t e;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);
    repeat (3) expect_v(V_NOP, 0, 0);
    expect_v(V_QFL, 0, 0);
    expect_v(V_QLO, 0, 0);
    expect_v(V_QHI, 0, 0);
    expect_v(V_RES, 0, 0);
    expect_v(V_IDLE, 1, 32'h40);
    for (int k = 0; sb.size() > 0; k++) begin
      drive(0, 0, k == 1, 0, 32'h77, 1);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL rti k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL rti k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);
    expect_v(V_ACK, 0, 0);
    repeat (3) expect_v(V_NOP, 0, 0);
    expect_v(V_PHI, 1, 32'h200);
    repeat (3) expect_v(V_PLO, 1, 32'h200);
    expect_v(V_PFL, 1, 32'h200);
    expect_v(V_VEC, 0, 0);
    expect_v(V_IDLE, 0, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      drive(0, k >= 1, 0, (k == 7) || (k == 8), 32'h200, 1);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL stall k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL stall k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [31:0] pc;
    logic        pcv;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);
    expect_entry(32'h100);
    expect_v(V_IDLE, 0, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      pc  = (k <= 3) ? 32'h40 : (k == 4) ? 32'h100 : 32'h999;
      pcv = (k <= 4);
      drive(0, k >= 1, 0, 0, pc, pcv);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL branch k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL branch k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic intr;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);
    expect_entry(32'h300);          // k=2..9, second edge lands at k=6
    expect_entry(32'h300);          // k=10..17, serviced straight from IDLE
    expect_v(V_IDLE, 0, 0);         // k=18
    expect_v(V_IDLE, 0, 0);         // k=19
    expect_v(V_IDLE, 0, 0);         // k=20 edge
    expect_entry(32'h300);          // k=21..28, RTI at k=21 is dropped
    expect_v(V_IDLE, 0, 0);         // k=29
    expect_v(V_IDLE, 0, 0);         // k=30
    for (int k = 0; sb.size() > 0; k++) begin
      intr = ((k >= 1) && (k <= 4)) || ((k >= 6) && (k <= 18)) || (k >= 20);
      drive(0, intr, k == 21, 0, 32'h300, 1);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL b2b k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL b2b k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    expect_v(V_IDLE, 0, 0);
    expect_v(V_IDLE, 0, 0);         // k=1 RTI accepted
    repeat (3) expect_v(V_NOP, 0, 0);
    expect_v(V_QFL, 0, 0);          // k=5
    expect_v(V_QLO, 0, 0);          // k=6 reset asserted
    expect_v(V_IDLE, 1, 32'h0);     // k=7
    repeat (4) expect_v(V_IDLE, 0, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      drive(k == 6, (k >= 3) && (k <= 5), k == 1, 0, 32'h55, 1);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL reset_mid k=%0d outputs got %b want %b", k, obs(), e.v);
      end
      if (e.chk_pc) begin
        checks++;
        if (bus.o_saved_pc !== e.pc) begin
          errors++;
          $display("FAIL reset_mid k=%0d saved_pc got %h want %h", k, bus.o_saved_pc, e.pc);
        end
      end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.i_interrupt     = 1'b0;
    bus.i_rti           = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_next_pc       = 32'h0;
    bus.i_next_pc_valid = 1'b0;
    test_reset();
    test_entry();
    test_rti();
    test_stall();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
